// File: rtl/wb_la_initiator_pkg.sv
// Shared definitions for the Wishbone single-transfer initiator.
//   ST_IDLE / ST_BUS / ST_RESP : FSM state encodings
//   sel_w()                    : byte-select width derived from a data width
package wb_la_initiator_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_BUS  = 2'd1;
    localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

    localparam int DEF_DAT_W = 32;
    localparam int DEF_SEL_W = DEF_DAT_W / 8;

    function automatic int sel_w(input int dat_w);
        return dat_w / 8;
    endfunction

endpackage

// File: rtl/wb_la_initiator.sv
// Wishbone classic single-transfer initiator.
// Turns one valid/ready command into one WB cycle and returns a response
// carrying read data, or an error flag when the responder never acks.
//
// Ports
//   wb_clk_i, wb_rst_n_i            clock, synchronous active-low reset
//   active                          block enable (low = idle, transfer dropped)
//   cmd_valid/cmd_ready             command handshake
//   cmd_we/cmd_adr/cmd_dat/cmd_sel  command fields
//   rsp_valid/rsp_ready             response handshake
//   rsp_dat/rsp_err                 read data / timeout flag
//   wbm_*                           Wishbone master interface
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for a command, cmd_ready follows active
// BUS     | cyc/stb asserted, waiting for ack or timeout
// RESP    | response presented until rsp_ready
module wb_la_initiator
    import wb_la_initiator_pkg::*;
#(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = DEF_DAT_W,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = sel_w(DAT_W)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             active,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    input  logic [SEL_W-1:0] cmd_sel,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,

    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    input  logic             wbm_ack_i,
    input  logic [DAT_W-1:0] wbm_dat_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last BUS cycle index (0-based) before the timeout fires, so cyc/stb
    // stay high for exactly TIMEOUT cycles when no ack arrives.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               we_q,    we_d;
    logic [ADR_W-1:0]   adr_q,   adr_d;
    logic [DAT_W-1:0]   dat_q,   dat_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;

    logic in_bus;
    logic in_resp;
    logic cmd_fire;
    logic rsp_fire;

    assign in_bus  = (state_q == ST_BUS);
    assign in_resp = (state_q == ST_RESP);

    // Gated by reset and active so nothing handshakes while the block is off.
    assign cmd_ready = wb_rst_n_i && active && (state_q == ST_IDLE);
    assign rsp_valid = wb_rst_n_i && active && in_resp;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    assign rsp_dat   = rsp_valid ? rsp_dat_q : '0;
    assign rsp_err   = rsp_valid && rsp_err_q;

    assign wbm_cyc_o = in_bus;
    assign wbm_stb_o = in_bus;
    assign wbm_we_o  = in_bus && we_q;
    assign wbm_adr_o = in_bus ? adr_q : '0;
    assign wbm_dat_o = in_bus ? dat_q : '0;
    assign wbm_sel_o = in_bus ? sel_q : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = ST_BUS;
                    cnt_d   = '0;
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                end
            end
            ST_BUS: begin
                // Ack is checked first so an ack on the final cycle wins.
                if (wbm_ack_i) begin
                    state_d   = ST_RESP;
                    rsp_dat_d = we_q ? '0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    cnt_d     = CNT_W'(TIMEOUT);
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping active abandons whatever is in flight, with no response.
        if (!active) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

endmodule
